// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: key codes, key types and scanner state encodings shared with the calculator FSM
package keypad_scanner_pkg;
   localparam logic [3:0] A_BUT       = 4'hA;
   localparam logic [3:0] B_BUT       = 4'hB;
   localparam logic [3:0] C_BUT       = 4'hC;
   localparam logic [3:0] D_BUT       = 4'hD;
   localparam logic [3:0] NUMERAL_BUT = 4'hE;
   localparam logic [3:0] FN_BUT      = 4'hF;
   localparam logic       NUMBER      = 1'b1;
   localparam logic       SYMBOL      = 1'b0;
   localparam logic [1:0] SCAN        = 2'd0;
   localparam logic [1:0] PRESS_DB    = 2'd1;
   localparam logic [1:0] HELD        = 2'd2;
   localparam logic [1:0] RELEASE_DB  = 2'd3;
endpackage

// File: rtl/keypad_scanner_input_sync.sv
// input_sync: 2-flop synchronizer of parameterized width
module input_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scanner with press/release debounce and key decode
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 20000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] row_result,
   input  logic       valid_out,
   output logic [1:0] col_selector,
   output logic [3:0] key,
   output logic       keytype,
   output logic       key_valid,
   output logic       number_signal,
   output logic       symbol_signal
);
   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
   localparam logic [19:0] DB_LAST  = 20'(DEBOUNCE - 1);
   // nibble index = {row, col}
   localparam logic [63:0] KEY_MAP = {D_BUT, NUMERAL_BUT, 4'h0, FN_BUT,
                                      C_BUT, 4'h9, 4'h8, 4'h7,
                                      B_BUT, 4'h6, 4'h5, 4'h4,
                                      A_BUT, 4'h3, 4'h2, 4'h1};
   logic [1:0]  rst_sh;
   logic        rst_n;
   logic [1:0]  row_s, row_l, state;
   logic        vld_s;
   logic [15:0] div_cnt;
   logic [19:0] cnt;
   logic [3:0]  key_code;
   always_ff @(posedge clock or negedge reset)
      if (!reset) rst_sh <= '0;
      else        rst_sh <= {rst_sh[0], 1'b1};
   assign rst_n = rst_sh[1];
   input_sync #(.WIDTH(3)) u_sync (
      .clock (clock),
      .reset (rst_n),
      .d     ({valid_out, row_result}),
      .q     ({vld_s, row_s})
   );
   assign key_code      = KEY_MAP[{row_l, col_selector, 2'b00} +: 4];
   assign number_signal = state[1] & keytype;
   assign symbol_signal = state[1] & ~keytype;
   always_ff @(posedge clock or negedge rst_n)
      if (!rst_n) begin
         state        <= SCAN;
         col_selector <= '0;
         div_cnt      <= '0;
         cnt          <= '0;
         row_l        <= '0;
         key          <= '0;
         keytype      <= SYMBOL;
         key_valid    <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            SCAN:
               if (div_cnt != DIV_LAST) div_cnt <= div_cnt + 16'd1;
               else begin
                  div_cnt <= '0;
                  if (vld_s) begin
                     row_l <= row_s;
                     cnt   <= '0;
                     state <= PRESS_DB;
                  end else col_selector <= col_selector + 2'd1;
               end
            PRESS_DB:
               if (!vld_s) begin
                  state        <= SCAN;
                  col_selector <= col_selector + 2'd1;
               end else if (row_s != row_l) begin
                  row_l <= row_s;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 20'd1;
                  if (cnt == DB_LAST) begin
                     key       <= key_code;
                     keytype   <= (key_code <= 4'd9) ? NUMBER : SYMBOL;
                     key_valid <= 1'b1;
                     state     <= HELD;
                  end
               end
            HELD:
               if (!vld_s) begin
                  cnt   <= '0;
                  state <= RELEASE_DB;
               end
            default:
               if (vld_s) begin
                  cnt   <= '0;
                  state <= HELD;
               end else begin
                  cnt <= cnt + 20'd1;
                  if (cnt == DB_LAST) begin
                     state        <= SCAN;
                     col_selector <= col_selector + 2'd1;
                  end
               end
         endcase
      end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed, table-driven checks of keypad_scanner against a behavioural keypad
module tb_keypad_scanner;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] row_result, col_selector;
   logic       valid_out;
   logic [3:0] key;
   logic       keytype, key_valid, number_signal, symbol_signal;
   logic       pressed [4][4];
   int         passed = 0, total = 0, strobes = 0;

   typedef struct {
      int         r;
      int         c;
      logic [3:0] k;
      logic       t;
   } vec_t;
   vec_t vecs [6];

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .row_result    (row_result),
      .valid_out     (valid_out),
      .col_selector  (col_selector),
      .key           (key),
      .keytype       (keytype),
      .key_valid     (key_valid),
      .number_signal (number_signal),
      .symbol_signal (symbol_signal)
   );

   always #5 clock = ~clock;

   // physical keypad plus priority row encoder (lowest row wins)
   always_comb begin
      valid_out  = 1'b0;
      row_result = 2'd0;
      for (int r = 3; r >= 0; r--)
         if (pressed[r][col_selector]) begin
            valid_out  = 1'b1;
            row_result = r[1:0];
         end
   end

   always @(negedge clock) if (key_valid) strobes++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_col(input logic [1:0] v);
      for (int i = 0; i < 50 && col_selector != v; i++) @(negedge clock);
      if (col_selector != v) chk("wait_col", col_selector, v);
   endtask

   task automatic wait_strobe(input string name);
      for (int i = 0; i < 100 && !key_valid; i++) @(negedge clock);
      if (!key_valid) chk(name, 0, 1);
   endtask

   task automatic press_check(input vec_t v);
      int s0, n;
      s0 = strobes;
      pressed[v.r][v.c] = 1'b1;
      wait_strobe("press_timeout");
      chk("key", key, v.k);
      chk("keytype", keytype, v.t);
      tick(30);
      chk("one_strobe", strobes - s0, 1);
      chk("number_signal", number_signal, v.t);
      chk("symbol_signal", symbol_signal, !v.t);
      chk("col_frozen", col_selector, v.c);
      pressed[v.r][v.c] = 1'b0;
      for (n = 0; n < 40 && col_selector == v.c; n++) @(negedge clock);
      chk("col_after_release", col_selector, (v.c + 1) % 4);
      chk("leds_off", {number_signal, symbol_signal}, 0);
      chk("key_held", key, v.k);
      chk("strobes_after_release", strobes - s0, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int prev, run, first, s0, n;
      vecs[0] = '{1, 2, 4'h6, 1'b1};
      vecs[1] = '{0, 0, 4'h1, 1'b1};
      vecs[2] = '{3, 1, 4'h0, 1'b1};
      vecs[3] = '{2, 3, 4'hC, 1'b0};
      vecs[4] = '{3, 2, 4'hE, 1'b0};
      vecs[5] = '{0, 3, 4'hA, 1'b0};
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
      tick(3);
      chk("rst_col", col_selector, 0);
      chk("rst_key", key, 0);
      chk("rst_outs", {keytype, key_valid, number_signal, symbol_signal}, 0);
      reset = 1'b1;
      // idle scan: every column change is +1 and every full dwell is 4 cycles
      prev = col_selector; run = 0; first = 1;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         run++;
         if (col_selector != prev[1:0]) begin
            chk("idle_step", col_selector, (prev + 1) % 4);
            if (!first) chk("idle_dwell", run, 4);
            first = 0; run = 0; prev = col_selector;
         end
      end
      chk("idle_no_strobe", strobes, 0);
      for (int i = 0; i < 6; i++) press_check(vecs[i]);
      // bouncing press of F at (r3,c0)
      wait_col(2'd3); wait_col(2'd0);
      s0 = strobes;
      pressed[3][0] = 1'b1; tick(1);
      pressed[3][0] = 1'b0; tick(1);
      pressed[3][0] = 1'b1; tick(1);
      pressed[3][0] = 1'b0; tick(1);
      pressed[3][0] = 1'b1; tick(2);
      wait_strobe("bounce_timeout");
      chk("bounce_key", key, 4'hF);
      chk("bounce_type", keytype, 0);
      tick(20);
      chk("bounce_symbol", symbol_signal, 1);
      chk("bounce_number", number_signal, 0);
      chk("bounce_strobes", strobes - s0, 1);
      // release bounce: low 5, high 2, then steady low
      pressed[3][0] = 1'b0; tick(5);
      pressed[3][0] = 1'b1; tick(2);
      chk("rel_bounce_col_frozen", col_selector, 0);
      chk("rel_bounce_led", symbol_signal, 1);
      pressed[3][0] = 1'b0;
      for (n = 0; n < 20 && col_selector == 2'd0; n++) tick(1);
      chk("rel_bounce_col", col_selector, 1);
      chk("rel_bounce_latency", (n >= 8 && n <= 14), 1);
      tick(20 - n);
      chk("rel_bounce_strobes", strobes - s0, 1);
      // two keys held: first in scan order wins
      wait_col(2'd3); wait_col(2'd0);
      s0 = strobes;
      pressed[0][1] = 1'b1; pressed[2][3] = 1'b1;
      wait_strobe("multi_timeout");
      chk("multi_key", key, 4'h2);
      tick(40);
      chk("multi_strobes", strobes - s0, 1);
      chk("multi_col", col_selector, 1);
      pressed[0][1] = 1'b0; pressed[2][3] = 1'b0;
      for (n = 0; n < 40 && col_selector == 2'd1; n++) tick(1);
      chk("multi_release_col", col_selector, 2);
      chk("multi_release_strobes", strobes - s0, 1);
      // reset while PRESS_DB has counted 5 stable cycles
      wait_col(2'd3); wait_col(2'd0);
      s0 = strobes;
      pressed[1][0] = 1'b1;
      tick(8);
      reset = 1'b0;
      #1;
      chk("mid_rst_key", key, 0);
      chk("mid_rst_col", col_selector, 0);
      chk("mid_rst_outs", {keytype, key_valid, number_signal, symbol_signal}, 0);
      tick(3);
      pressed[1][0] = 1'b0;
      reset = 1'b1;
      tick(3);
      chk("post_rst_col", col_selector, 0);
      tick(20);
      chk("post_rst_no_strobe", strobes - s0, 0);
      chk("post_rst_key", key, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
